// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending payment sequencer.
//   pay_state_t      payment FSM states
//   COIN_V1/5/10     coin face values in 1-yuan units
//   *_DEF            default widths and cycle counts
//   max_u()          helper for sizing the shared timer
package vend_pkg;

  localparam int unsigned PW_DEF          = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 50_000_000;
  localparam int unsigned HOLD_CYC_DEF    = 150_000_000;

  localparam int unsigned COIN_V1  = 1;
  localparam int unsigned COIN_V5  = 5;
  localparam int unsigned COIN_V10 = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    REFUND   = 3'd3,
    HOLD     = 3'd4
  } pay_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_pay_ctrl_if.sv
// vend_pay_ctrl_if: order/coin inputs and payment result outputs of the sequencer.
//   master modport: drives start/price/coins/cancel/abort, observes results
//   slave  modport: the payment sequencer itself
interface vend_pay_ctrl_if #(
  parameter int unsigned PW = 8
) ();

  logic          start;
  logic [PW-1:0] price;
  logic          coin_1;
  logic          coin_5;
  logic          coin_10;
  logic          cancel;
  logic          abort;

  logic [PW-1:0] paid;
  logic          busy;
  logic          dispense;
  logic [PW-1:0] change;
  logic          refund_vld;
  logic [PW-1:0] refund_amt;
  logic          coin_reject;
  logic          success;
  logic          failure;
  logic          finish;

  modport master (
    output start, price, coin_1, coin_5, coin_10, cancel, abort,
    input  paid, busy, dispense, change, refund_vld, refund_amt,
           coin_reject, success, failure, finish
  );

  modport slave (
    input  start, price, coin_1, coin_5, coin_10, cancel, abort,
    output paid, busy, dispense, change, refund_vld, refund_amt,
           coin_reject, success, failure, finish
  );

endinterface

// File: rtl/vend_timer.sv
// vend_timer: loadable down-counter shared by the payment timeout and result hold.
//   clk, rst_n        clock, async active-low reset
//   i_load/i_load_val load a new count (wins over i_en)
//   i_en              decrement by one, saturating at zero
//   o_expire          registered: counter currently holds 1 (last cycle of the interval)
//   o_expire_nxt_c    combinational: counter will hold 1 after the next edge
module vend_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expire,
  output logic         o_expire_nxt_c
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_d;
  logic         r_expire;

  // Next count: load, else decrement while non-zero
  always_comb begin
    w_cnt_d = r_cnt;
    if (i_load) begin
      w_cnt_d = i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      w_cnt_d = r_cnt - W'(1);
    end
  end

  assign o_expire_nxt_c = (w_cnt_d == W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_d;
      r_expire <= o_expire_nxt_c;
    end
  end

  assign o_expire = r_expire;

endmodule

// File: rtl/vend_pay_ctrl.sv
// vend_pay_ctrl: payment sequencer. Latches the price on start, counts coins,
// then dispenses (with change) or refunds, holds the result and pulses finish.
//   clk, rst_n   clock, async active-low reset
//   bus (slave)  start/price/coin_1/coin_5/coin_10/cancel/abort in;
//                paid/busy/dispense/change/refund_vld/refund_amt/
//                coin_reject/success/failure/finish out (all registered)
// Build option: VEND_CHANGE_EN enables overpayment with change; without it
// only exact payment completes and change is tied to 0.
module vend_pay_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PW          = PW_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  vend_pay_ctrl_if.slave bus
);

  localparam int unsigned TW = $clog2(max_u(TIMEOUT_CYC, HOLD_CYC) + 1);

  pay_state_t    r_state, w_state_d;
  logic [PW-1:0] r_paid, w_paid_d;
  logic [PW-1:0] r_price, w_price_d;

  logic          r_busy, r_dispense, r_refund_vld, r_coin_reject;
  logic          r_success, r_failure, r_finish;
  logic [PW-1:0] r_refund_amt;

  logic          w_busy_d, w_dispense_d, w_refund_vld_d, w_coin_reject_d;
  logic          w_success_d, w_failure_d, w_finish_d;
  logic [PW-1:0] w_refund_amt_d;

  logic [PW-1:0] w_coin_val;
  logic          w_coin_any, w_coin_multi, w_coin_fits;
  logic [PW:0]   w_sum;
  logic          w_accept, w_abort_rf;

  logic          w_tmr_load, w_tmr_en, w_tmr_expire, w_tmr_expire_nxt_c;
  logic [TW-1:0] w_tmr_val;

  vend_timer #(.W(TW)) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load         (w_tmr_load),
    .i_load_val     (w_tmr_val),
    .i_en           (w_tmr_en),
    .o_expire       (w_tmr_expire),
    .o_expire_nxt_c (w_tmr_expire_nxt_c)
  );

  // Coin decode: one coin counted per cycle, 10 > 5 > 1
  always_comb begin
    w_coin_val = '0;
    if (bus.coin_10)      w_coin_val = PW'(COIN_V10);
    else if (bus.coin_5)  w_coin_val = PW'(COIN_V5);
    else if (bus.coin_1)  w_coin_val = PW'(COIN_V1);
  end

  assign w_coin_any   = bus.coin_1 | bus.coin_5 | bus.coin_10;
  assign w_coin_multi = (bus.coin_1 & bus.coin_5) | (bus.coin_1 & bus.coin_10) |
                        (bus.coin_5 & bus.coin_10);
  assign w_sum        = {1'b0, r_paid} + {1'b0, w_coin_val};

`ifdef VEND_CHANGE_EN
  assign w_coin_fits = !w_sum[PW];
`else
  // Without change, a coin may not push paid past the price
  assign w_coin_fits = !w_sum[PW] && (w_sum <= {1'b0, r_price});
`endif

  // Next-state, datapath and timer control
  always_comb begin
    w_state_d  = r_state;
    w_paid_d   = r_paid;
    w_price_d  = r_price;
    w_accept   = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    w_tmr_val  = TW'(TIMEOUT_CYC);
    w_abort_rf = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_price_d  = bus.price;
          w_paid_d   = '0;
          w_tmr_load = 1'b1;
          w_state_d  = COLLECT;
        end
      end
      COLLECT: begin
        w_tmr_en = 1'b1;
        if (w_coin_any && w_coin_fits) begin
          w_accept   = 1'b1;
          w_paid_d   = w_sum[PW-1:0];
          w_tmr_load = 1'b1;
        end
        // Cancel beats completion; an accepted coin is kept either way
        if (bus.cancel) begin
          w_state_d = REFUND;
        end else if ({1'b0, w_paid_d} >= {1'b0, r_price}) begin
          w_state_d = DISPENSE;
        end else if (w_tmr_expire && !w_accept) begin
          w_state_d = REFUND;
        end
      end
      DISPENSE, REFUND: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = TW'(HOLD_CYC);
        w_state_d  = HOLD;
      end
      HOLD: begin
        w_tmr_en = 1'b1;
        if (w_tmr_expire) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase

    // Hard stop overrides everything outside IDLE
    if (bus.abort && (r_state != IDLE)) begin
      w_state_d  = IDLE;
      w_paid_d   = r_paid;
      w_accept   = 1'b0;
      w_tmr_load = 1'b0;
      w_tmr_en   = 1'b0;
      w_abort_rf = 1'b1;
    end
  end

  // Output next values, registered below so they line up with the state
  always_comb begin
    w_busy_d        = (w_state_d != IDLE);
    w_dispense_d    = (w_state_d == DISPENSE);
    w_refund_vld_d  = 1'b0;
    w_refund_amt_d  = '0;
    if (w_abort_rf) begin
      w_refund_vld_d = (r_paid != '0);
      w_refund_amt_d = r_paid;
    end else if (w_state_d == REFUND) begin
      w_refund_vld_d = 1'b1;
      w_refund_amt_d = w_paid_d;
    end
    w_coin_reject_d = w_coin_multi || (w_coin_any && !w_accept);
    w_success_d     = (w_state_d == HOLD) && ((r_state == DISPENSE) || r_success);
    w_failure_d     = (w_state_d == HOLD) && ((r_state == REFUND) || r_failure);
    w_finish_d      = (w_state_d == HOLD) && w_tmr_expire_nxt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_paid        <= '0;
      r_price       <= '0;
      r_busy        <= 1'b0;
      r_dispense    <= 1'b0;
      r_refund_vld  <= 1'b0;
      r_refund_amt  <= '0;
      r_coin_reject <= 1'b0;
      r_success     <= 1'b0;
      r_failure     <= 1'b0;
      r_finish      <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_paid        <= w_paid_d;
      r_price       <= w_price_d;
      r_busy        <= w_busy_d;
      r_dispense    <= w_dispense_d;
      r_refund_vld  <= w_refund_vld_d;
      r_refund_amt  <= w_refund_amt_d;
      r_coin_reject <= w_coin_reject_d;
      r_success     <= w_success_d;
      r_failure     <= w_failure_d;
      r_finish      <= w_finish_d;
    end
  end

`ifdef VEND_CHANGE_EN
  logic [PW-1:0] r_change;

  // Change is meaningful only alongside dispense
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_change <= '0;
    end else begin
      r_change <= w_dispense_d ? (w_paid_d - r_price) : '0;
    end
  end

  assign bus.change = r_change;
`else
  assign bus.change = '0;
`endif

  assign bus.paid        = r_paid;
  assign bus.busy        = r_busy;
  assign bus.dispense    = r_dispense;
  assign bus.refund_vld  = r_refund_vld;
  assign bus.refund_amt  = r_refund_amt;
  assign bus.coin_reject = r_coin_reject;
  assign bus.success     = r_success;
  assign bus.failure     = r_failure;
  assign bus.finish      = r_finish;

endmodule

// File: tb/tb_vend_pay_ctrl.sv
// tb_vend_pay_ctrl: directed scenarios for vend_pay_ctrl with PW=8,
// TIMEOUT_CYC=20, HOLD_CYC=4; overpayment expectations follow VEND_CHANGE_EN.
module tb_vend_pay_ctrl;

  localparam int unsigned PW = 8;
  localparam int unsigned TO = 20;
  localparam int unsigned HC = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  vend_pay_ctrl_if #(.PW(PW)) vif ();

  vend_pay_ctrl #(.PW(PW), .TIMEOUT_CYC(TO), .HOLD_CYC(HC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.start   = 1'b0;
    vif.price   = '0;
    vif.coin_1  = 1'b0;
    vif.coin_5  = 1'b0;
    vif.coin_10 = 1'b0;
    vif.cancel  = 1'b0;
    vif.abort   = 1'b0;
  endtask

  task automatic begin_order(input logic [PW-1:0] p);
    vif.start = 1'b1;
    vif.price = p;
    tick();
    vif.start = 1'b0;
    vif.price = '0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    flags = {vif.busy, vif.dispense, vif.refund_vld, vif.coin_reject,
             vif.success, vif.failure, vif.finish};
    n_checks++;
    if (flags !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000000", flags);
    end
    n_checks++;
    if ({vif.paid, vif.change, vif.refund_amt} !== 24'h0) begin
      n_fail++; $display("FAIL reset_amounts: paid=%0d change=%0d refund_amt=%0d expected all 0",
                         vif.paid, vif.change, vif.refund_amt);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (vif.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_busy: got %b expected 0", vif.busy);
    end
  endtask

  task automatic test_exact_payment();
    begin_order(8'd12);
    n_checks++;
    if (vif.busy !== 1'b1 || vif.paid !== 8'd0) begin
      n_fail++; $display("FAIL exact_start: busy=%b paid=%0d expected busy=1 paid=0", vif.busy, vif.paid);
    end
    // start while busy must not relatch the price
    begin_order(8'd3);
    vif.coin_10 = 1'b1; tick(); vif.coin_10 = 1'b0;
    n_checks++;
    if (vif.paid !== 8'd10 || vif.dispense !== 1'b0) begin
      n_fail++; $display("FAIL exact_coin10: paid=%0d dispense=%b expected 10/0", vif.paid, vif.dispense);
    end
    vif.coin_1 = 1'b1; tick(); tick(); vif.coin_1 = 1'b0;
    n_checks++;
    if (vif.paid !== 8'd12 || vif.dispense !== 1'b1 || vif.change !== 8'd0) begin
      n_fail++; $display("FAIL exact_dispense: paid=%0d dispense=%b change=%0d expected 12/1/0",
                         vif.paid, vif.dispense, vif.change);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({vif.success, vif.finish, vif.dispense} !== {1'b1, (i == 4), 1'b0}) begin
        n_fail++; $display("FAIL exact_hold%0d: success=%b finish=%b dispense=%b expected 1/%0d/0",
                           i, vif.success, vif.finish, vif.dispense, (i == 4));
      end
    end
    tick();
    n_checks++;
    if (vif.busy !== 1'b0 || vif.success !== 1'b0 || vif.finish !== 1'b0 || vif.paid !== 8'd12) begin
      n_fail++; $display("FAIL exact_idle: busy=%b success=%b finish=%b paid=%0d expected 0/0/0/12",
                         vif.busy, vif.success, vif.finish, vif.paid);
    end
  endtask

  task automatic test_overpay();
    begin_order(8'd12);
    vif.coin_10 = 1'b1; tick(); tick(); vif.coin_10 = 1'b0;
`ifdef VEND_CHANGE_EN
    n_checks++;
    if (vif.paid !== 8'd20 || vif.dispense !== 1'b1 || vif.change !== 8'd8 || vif.coin_reject !== 1'b0) begin
      n_fail++; $display("FAIL overpay_change: paid=%0d dispense=%b change=%0d reject=%b expected 20/1/8/0",
                         vif.paid, vif.dispense, vif.change, vif.coin_reject);
    end
`else
    n_checks++;
    if (vif.paid !== 8'd10 || vif.dispense !== 1'b0 || vif.coin_reject !== 1'b1 || vif.change !== 8'd0) begin
      n_fail++; $display("FAIL overpay_reject: paid=%0d dispense=%b reject=%b change=%0d expected 10/0/1/0",
                         vif.paid, vif.dispense, vif.coin_reject, vif.change);
    end
    vif.cancel = 1'b1; tick(); vif.cancel = 1'b0;
    n_checks++;
    if (vif.refund_vld !== 1'b1 || vif.refund_amt !== 8'd10) begin
      n_fail++; $display("FAIL overpay_refund: vld=%b amt=%0d expected 1/10", vif.refund_vld, vif.refund_amt);
    end
`endif
    repeat (5) tick();
    n_checks++;
    if (vif.busy !== 1'b0) begin
      n_fail++; $display("FAIL overpay_idle: busy=%b expected 0", vif.busy);
    end
  endtask

  task automatic test_simultaneous();
    vif.coin_1 = 1'b1; tick(); vif.coin_1 = 1'b0;
    n_checks++;
    if (vif.coin_reject !== 1'b1 || vif.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_coin: reject=%b busy=%b expected 1/0", vif.coin_reject, vif.busy);
    end
    begin_order(8'd30);
    vif.coin_5 = 1'b1; vif.coin_10 = 1'b1; tick(); vif.coin_5 = 1'b0; vif.coin_10 = 1'b0;
    n_checks++;
    if (vif.paid !== 8'd10 || vif.coin_reject !== 1'b1) begin
      n_fail++; $display("FAIL simul_5_10: paid=%0d reject=%b expected 10/1", vif.paid, vif.coin_reject);
    end
    tick();
    n_checks++;
    if (vif.coin_reject !== 1'b0) begin
      n_fail++; $display("FAIL simul_reject_width: reject=%b expected 0", vif.coin_reject);
    end
    vif.coin_1 = 1'b1; vif.coin_5 = 1'b1; vif.coin_10 = 1'b1; tick();
    vif.coin_1 = 1'b0; vif.coin_5 = 1'b0; vif.coin_10 = 1'b0;
    n_checks++;
    if (vif.paid !== 8'd20 || vif.coin_reject !== 1'b1) begin
      n_fail++; $display("FAIL simul_all3: paid=%0d reject=%b expected 20/1", vif.paid, vif.coin_reject);
    end
    vif.cancel = 1'b1; tick(); vif.cancel = 1'b0;
    n_checks++;
    if (vif.refund_vld !== 1'b1 || vif.refund_amt !== 8'd20) begin
      n_fail++; $display("FAIL simul_cancel: vld=%b amt=%0d expected 1/20", vif.refund_vld, vif.refund_amt);
    end
    repeat (5) tick();
  endtask

  task automatic test_timeout();
    int k;
    k = 0;
    begin_order(8'd15);
    tick(); tick();
    vif.coin_5 = 1'b1; tick(); vif.coin_5 = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (vif.refund_vld === 1'b1) begin
        k = i;
        break;
      end
    end
    n_checks++;
    if (k !== 20) begin
      n_fail++; $display("FAIL timeout_latency: refund after %0d cycles (0 = none) expected 20", k);
    end
    n_checks++;
    if (vif.refund_amt !== 8'd5 || vif.failure !== 1'b0) begin
      n_fail++; $display("FAIL timeout_amt: amt=%0d failure=%b expected 5/0", vif.refund_amt, vif.failure);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({vif.failure, vif.finish, vif.refund_vld} !== {1'b1, (i == 4), 1'b0}) begin
        n_fail++; $display("FAIL timeout_hold%0d: failure=%b finish=%b refund_vld=%b expected 1/%0d/0",
                           i, vif.failure, vif.finish, vif.refund_vld, (i == 4));
      end
    end
    tick();
    n_checks++;
    if (vif.busy !== 1'b0 || vif.failure !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: busy=%b failure=%b expected 0/0", vif.busy, vif.failure);
    end
  endtask

  task automatic test_cancel_vs_complete();
    logic seen_disp;
    begin_order(8'd5);
    vif.cancel = 1'b1; vif.coin_5 = 1'b1; tick(); vif.cancel = 1'b0; vif.coin_5 = 1'b0;
    n_checks++;
    if (vif.refund_vld !== 1'b1 || vif.refund_amt !== 8'd5 || vif.dispense !== 1'b0) begin
      n_fail++; $display("FAIL cancel_refund: vld=%b amt=%0d dispense=%b expected 1/5/0",
                         vif.refund_vld, vif.refund_amt, vif.dispense);
    end
    tick();
    n_checks++;
    if (vif.failure !== 1'b1 || vif.success !== 1'b0) begin
      n_fail++; $display("FAIL cancel_result: failure=%b success=%b expected 1/0", vif.failure, vif.success);
    end
    seen_disp = 1'b0;
    repeat (4) begin
      tick();
      seen_disp = seen_disp | vif.dispense;
    end
    n_checks++;
    if (seen_disp !== 1'b0 || vif.busy !== 1'b0) begin
      n_fail++; $display("FAIL cancel_nodisp: dispense_seen=%b busy=%b expected 0/0", seen_disp, vif.busy);
    end
  endtask

  task automatic test_price_zero();
    begin_order(8'd0);
    n_checks++;
    if (vif.busy !== 1'b1 || vif.dispense !== 1'b0) begin
      n_fail++; $display("FAIL zero_collect: busy=%b dispense=%b expected 1/0", vif.busy, vif.dispense);
    end
    tick();
    n_checks++;
    if (vif.dispense !== 1'b1 || vif.change !== 8'd0) begin
      n_fail++; $display("FAIL zero_dispense: dispense=%b change=%0d expected 1/0", vif.dispense, vif.change);
    end
    repeat (5) tick();
  endtask

  task automatic test_overflow();
    begin_order(8'd255);
    vif.coin_10 = 1'b1;
    repeat (25) tick();
    n_checks++;
    if (vif.paid !== 8'd250) begin
      n_fail++; $display("FAIL ovf_fill: paid=%0d expected 250", vif.paid);
    end
    tick();
    vif.coin_10 = 1'b0;
    n_checks++;
    if (vif.paid !== 8'd250 || vif.coin_reject !== 1'b1 || vif.dispense !== 1'b0) begin
      n_fail++; $display("FAIL ovf_reject: paid=%0d reject=%b dispense=%b expected 250/1/0",
                         vif.paid, vif.coin_reject, vif.dispense);
    end
    vif.coin_5 = 1'b1; tick(); vif.coin_5 = 1'b0;
    n_checks++;
    if (vif.paid !== 8'd255 || vif.dispense !== 1'b1 || vif.change !== 8'd0) begin
      n_fail++; $display("FAIL ovf_complete: paid=%0d dispense=%b change=%0d expected 255/1/0",
                         vif.paid, vif.dispense, vif.change);
    end
    repeat (5) tick();
  endtask

  task automatic test_abort();
    logic seen;
    begin_order(8'd20);
    vif.coin_5 = 1'b1; tick(); vif.coin_5 = 1'b0;
    vif.coin_1 = 1'b1; tick(); vif.coin_1 = 1'b0;
    n_checks++;
    if (vif.paid !== 8'd6) begin
      n_fail++; $display("FAIL abort_paid: paid=%0d expected 6", vif.paid);
    end
    vif.abort = 1'b1; tick(); vif.abort = 1'b0;
    n_checks++;
    if (vif.refund_vld !== 1'b1 || vif.refund_amt !== 8'd6 || vif.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_refund: vld=%b amt=%0d busy=%b expected 1/6/0",
                         vif.refund_vld, vif.refund_amt, vif.busy);
    end
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | vif.finish | vif.dispense | vif.refund_vld;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet: finish/dispense/refund seen=%b expected 0", seen);
    end
    begin_order(8'd9);
    vif.abort = 1'b1; tick(); vif.abort = 1'b0;
    n_checks++;
    if (vif.refund_vld !== 1'b0 || vif.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_zero: vld=%b busy=%b expected 0/0", vif.refund_vld, vif.busy);
    end
  endtask

  task automatic test_reset_mid();
    begin_order(8'd1);
    vif.coin_1 = 1'b1; tick(); vif.coin_1 = 1'b0;
    tick();
    n_checks++;
    if (vif.success !== 1'b1 || vif.busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_hold: success=%b busy=%b expected 1/1", vif.success, vif.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vif.busy, vif.dispense, vif.refund_vld, vif.coin_reject, vif.success, vif.failure, vif.finish} !== 7'b0 ||
        {vif.paid, vif.change, vif.refund_amt} !== 24'h0) begin
      n_fail++; $display("FAIL rstmid_async: busy=%b success=%b refund_vld=%b paid=%0d expected all 0",
                         vif.busy, vif.success, vif.refund_vld, vif.paid);
    end
    #2 rst_n = 1'b1;
    tick();
    n_checks++;
    if (vif.busy !== 1'b0 || vif.refund_vld !== 1'b0 || vif.finish !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: busy=%b refund_vld=%b finish=%b expected 0/0/0",
                         vif.busy, vif.refund_vld, vif.finish);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_exact_payment();
    test_overpay();
    test_simultaneous();
    test_timeout();
    test_cancel_vs_complete();
    test_price_zero();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
